// File: rtl/dot_product_stream_accel_if.sv
// Element-pair stream into the dot-product accelerator; lane i sits at bits [i*DATA_W +: DATA_W].
interface dot_product_stream_accel_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_a;
    logic [LANES*DATA_W-1:0] in_b;

    modport master (output in_valid, in_a, in_b, input in_ready);
    modport slave  (input in_valid, in_a, in_b, output in_ready);
endinterface

// File: rtl/dot_product_stream_accel.sv
// Streaming signed dot product, LANES pairs/beat; `DOT_PRODUCT_SAT_EN` saturates the result to RES_W.
// Result 3 edges after the final beat; in_ready is a registered RUN decode, low outside RUN.
module dot_product_stream_accel #(
    parameter int DATA_W  = 32,
    parameter int LANES   = 2,
    parameter int MAX_LEN = 64,
    parameter int ACC_W   = 2*DATA_W+8,
    parameter int RES_W   = 64,
    parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [LEN_W-1:0]         len_i,
    input  logic                     accumulate_i,
    dot_product_stream_accel_if.slave s_if,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [RES_W-1:0]         result_o,
    output logic                     overflow_o
);
    localparam int PROD_W = 2*DATA_W;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                   state_q;
    logic [LEN_W-1:0]         rem_q;
    logic [LEN_W-1:0]         len_clamp_d;
    logic                     in_ready_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     s1_vld_q;
    logic [1:0]               drain_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  lane_sum_d;
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic [RES_W-1:0]         result_q;
    logic [RES_W-1:0]         result_d;
    logic                     fire;
    logic                     last_beat;
    logic                     start_acc;
    logic                     finish;

    assign fire        = s_if.in_valid && in_ready_q;
    assign last_beat   = int'(rem_q) <= LANES;
    assign len_clamp_d = (int'(len_i) > MAX_LEN) ? LEN_W'(MAX_LEN) : len_i;
    assign start_acc   = (state_q == ST_IDLE || state_q == ST_DONE) && start_i && !abort_i;
    assign finish      = (state_q == ST_DRAIN) && !abort_i && (drain_q == 2'd0);

    // rem_q counts elements still owed, so lanes at or beyond it are padding
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = '0;
            if (int'(rem_q) > i)
                prod_d[i] = PROD_W'(signed'(s_if.in_a[i*DATA_W +: DATA_W]))
                          * PROD_W'(signed'(s_if.in_b[i*DATA_W +: DATA_W]));
        end
    end

    always_comb begin
        lane_sum_d = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum_d = lane_sum_d + ACC_W'(prod_q[i]);
    end

`ifdef DOT_PRODUCT_SAT_EN
    logic                   ovf_q;
    logic                   fits_d;
    logic [ACC_W-RES_W:0]   acc_top;

    // representable iff every bit from the RES_W sign bit upward agrees
    assign acc_top = acc_q[ACC_W-1:RES_W-1];
    assign fits_d  = (&acc_top) || !(|acc_top);

    always_comb begin
        result_d = acc_q[RES_W-1:0];
        if (!fits_d)
            result_d = acc_q[ACC_W-1] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (start_acc)
            ovf_q <= 1'b0;
        else if (finish)
            ovf_q <= !fits_d;
    end

    assign overflow_o = ovf_q;
`else
    always_comb result_d = acc_q[RES_W-1:0];
    assign overflow_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            drain_q    <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
        end else begin
            s1_vld_q <= fire && !abort_i;
            for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
            if (s1_vld_q)
                acc_q <= acc_q + lane_sum_d;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_acc) begin
                        rem_q   <= len_clamp_d;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        drain_q <= 2'd2;
                        if (!accumulate_i)
                            acc_q <= '0;
                        if (len_clamp_d == '0) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q    <= ST_RUN;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        rem_q      <= '0;
                        acc_q      <= '0;
                    end else if (fire && last_beat) begin
                        state_q    <= ST_DRAIN;
                        in_ready_q <= 1'b0;
                        rem_q      <= '0;
                    end else if (fire) begin
                        rem_q <= rem_q - LEN_W'(LANES);
                    end
                end
                ST_DRAIN: begin
                    // two edges for the product and accumulate stages, then publish
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        acc_q   <= '0;
                    end else if (drain_q == 2'd0) begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end else begin
                        drain_q <= drain_q - 2'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_if.in_ready = in_ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign result_o      = result_q;
endmodule

// File: tb/tb_dot_product_stream_accel.sv
// Randomised scoreboard bench for dot_product_stream_accel with a plain-arithmetic reference model.
module tb_dot_product_stream_accel;
    localparam int DW = 32;
    localparam int LN = 2;
    localparam int ML = 64;
    localparam int AW = 2*DW+8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        accumulate;
    logic [6:0]  len;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [63:0] result;

    always #5 clk = ~clk;

    dot_product_stream_accel_if #(.DATA_W(DW), .LANES(LN)) s_if ();

    dot_product_stream_accel dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .abort_i      (abort),
        .len_i        (len),
        .accumulate_i (accumulate),
        .s_if         (s_if),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .overflow_o   (overflow)
    );

    int                    total = 0;
    int                    bad   = 0;
    logic [64:0]           exp_q[$];
    logic signed [AW-1:0]  acc_m;
    logic [63:0]           last_res;
    bit                    done_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // monitor: every rising done consumes one scoreboard entry
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result %0h expected no completion", result);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("result", result, e[63:0]);
                chk("overflow", 64'(overflow), 64'(e[64]));
            end
        end
        done_prev = done;
    end

    function automatic logic [31:0] elem(input int q[$], input int e);
        if (e < q.size()) return q[e];
        return $urandom;
    endfunction

    task automatic model_push(input int n, input bit acc_en, input int ea[$], input int eb[$]);
        logic [63:0]          r;
        logic                 o;
        logic signed [AW-1:0] smax;
        logic signed [AW-1:0] smin;
        smax = AW'(64'sh7FFF_FFFF_FFFF_FFFF);
        smin = -smax - 1;
        if (!acc_en) acc_m = '0;
        for (int e = 0; e < n; e++)
            acc_m = acc_m + (AW'(ea[e]) * AW'(eb[e]));
`ifdef DOT_PRODUCT_SAT_EN
        if (acc_m > smax) begin
            r = 64'h7FFF_FFFF_FFFF_FFFF; o = 1'b1;
        end else if (acc_m < smin) begin
            r = 64'h8000_0000_0000_0000; o = 1'b1;
        end else begin
            r = acc_m[63:0]; o = 1'b0;
        end
`else
        r = acc_m[63:0];
        o = 1'b0;
`endif
        exp_q.push_back({o, r});
        last_res = r;
    endtask

    task automatic run(input int n_len, input bit acc_en, input bit gaps, input int ea[$], input int eb[$]);
        int n, nb, beat, cyc, cnt;
        bit pbusy;
        n  = (n_len > ML) ? ML : n_len;
        nb = (n + LN - 1) / LN;
        @(negedge clk);
        start = 1'b1; len = 7'(n_len); accumulate = acc_en;
        @(negedge clk);
        start = 1'b0; len = 7'($urandom); accumulate = ~acc_en;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("ready_after_start", 64'(s_if.in_ready), 64'(nb > 0));
        beat = 0;
        cyc  = 0;
        while (beat < nb && cyc < 200) begin
            s_if.in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            s_if.in_a = {elem(ea, beat*LN+1), elem(ea, beat*LN)};
            s_if.in_b = {elem(eb, beat*LN+1), elem(eb, beat*LN)};
            if (s_if.in_valid && s_if.in_ready) beat++;
            cyc++;
            @(negedge clk);
        end
        chk("beats_accepted", 64'(beat), 64'(nb));
        s_if.in_valid = gaps;
        s_if.in_a = {$urandom, $urandom};
        s_if.in_b = {$urandom, $urandom};
        chk("ready_after_last", 64'(s_if.in_ready), 64'd0);
        model_push(n, acc_en, ea, eb);
        cnt   = 1;
        pbusy = 1'b0;
        while (!done && cnt < 12) begin
            pbusy = busy;
            @(negedge clk);
            cnt++;
        end
        chk("done_latency", 64'(cnt), 64'd4);
        chk("busy_before_done", 64'(pbusy), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        s_if.in_valid = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1);
    end

    initial begin
        int qa[$], qb[$];
        rst = 1'b1; start = 1'b0; abort = 1'b0; accumulate = 1'b0; len = '0;
        s_if.in_valid = 1'b0; s_if.in_a = '0; s_if.in_b = '0;
        acc_m = '0; last_res = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(s_if.in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;

        // 1..8 against ones, continuous and then with gaps
        for (int e = 1; e <= 8; e++) begin qa.push_back(e); qb.push_back(1); end
        run(8, 1'b0, 1'b0, qa, qb);
        qa.delete(); qb.delete();
        for (int e = 0; e < 5; e++) begin qa.push_back(-2); qb.push_back(3); end
        qa.push_back(100); qb.push_back(100);
        run(5, 1'b0, 1'b0, qa, qb);
        qa.delete(); qb.delete();
        for (int e = 1; e <= 8; e++) begin qa.push_back(e); qb.push_back(1); end
        run(8, 1'b0, 1'b1, qa, qb);

        // accumulate chain
        qa.delete(); qb.delete();
        qa.push_back(3); qa.push_back(4); qb.push_back(1); qb.push_back(1);
        run(2, 1'b0, 1'b0, qa, qb);
        qa.delete(); qa.push_back(5); qa.push_back(5);
        run(2, 1'b1, 1'b0, qa, qb);
        run(2, 1'b0, 1'b0, qa, qb);

        // start together with abort in DONE is ignored
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("startabort_busy", 64'(busy), 64'd0);
        chk("startabort_done", 64'(done), 64'd1);

        // abort after two of four beats
        @(negedge clk); start = 1'b1; len = 7'd8; accumulate = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            abort = (b == 2);
            s_if.in_valid = 1'b1;
            s_if.in_a = {32'(2*b+2), 32'(2*b+1)};
            s_if.in_b = {32'd1, 32'd1};
            @(negedge clk);
        end
        abort = 1'b0; s_if.in_valid = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(s_if.in_ready), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result_kept", result, last_res);
        acc_m = '0;
        qa.delete(); qb.delete();
        qa.push_back(2); qa.push_back(4); qb.push_back(3); qb.push_back(5);
        run(2, 1'b1, 1'b0, qa, qb);

        // four products of 2^62
        qa.delete(); qb.delete();
        for (int e = 0; e < 4; e++) begin qa.push_back(32'h8000_0000); qb.push_back(32'h8000_0000); end
        run(4, 1'b0, 1'b0, qa, qb);
        run(0, 1'b1, 1'b0, qa, qb);

        for (int r = 0; r < 20; r++) begin
            qa.delete(); qb.delete();
            for (int e = 0; e < ML + 2; e++) begin
                qa.push_back(($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom);
                qb.push_back(($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom);
            end
            run($urandom_range(0, 100), 1'($urandom), 1'($urandom), qa, qb);
        end

        // synchronous reset in the middle of a run
        @(negedge clk); start = 1'b1; len = 7'd10; accumulate = 1'b1;
        @(negedge clk); start = 1'b0;
        s_if.in_valid = 1'b1; s_if.in_a = {32'd7, 32'd7}; s_if.in_b = {32'd7, 32'd7};
        @(negedge clk); s_if.in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_ready", 64'(s_if.in_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        acc_m = '0;
        qa.delete(); qb.delete();
        for (int e = 0; e < 3; e++) begin qa.push_back(e + 1); qb.push_back(-1); end
        run(3, 1'b1, 1'b0, qa, qb);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
